// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the pipelined mux tree
package mux_pkg;
  localparam int MUX_MAX_IN = 256;
  function automatic int clog2(input int n);
    for (int r = 0; r < 32; r++)
      if ((1 << r) >= n) return r;
    return 32;
  endfunction
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction
  // lane offset of tree level k inside the flattened all-levels bus (level 0 = inputs)
  function automatic int lvl_off(input int n, input int k);
    return 2 * n - 2 * (n >> k);
  endfunction
endpackage

// File: rtl/mux_tree_stage.sv
// mux_tree_stage: one registered 2:1 level of the mux tree
// Ports: clk, rst_n (async active-low), i_en (shift enable), i_valid/i_data/i_sel (level input),
//        o_valid/o_data/o_sel (registered level output, half the lanes)
module mux_tree_stage import mux_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int LANES_IN = 2,
  parameter int SEL_W    = 1,
  parameter int SEL_IDX  = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_en,
  input  logic                            i_valid,
  input  logic [LANES_IN*DATA_W-1:0]      i_data,
  input  logic [SEL_W-1:0]                i_sel,
  output logic                            o_valid,
  output logic [(LANES_IN/2)*DATA_W-1:0]  o_data,
  output logic [SEL_W-1:0]                o_sel
);
  localparam int LANES_OUT = LANES_IN / 2;
  logic [LANES_OUT*DATA_W-1:0] w_mux;
  logic [LANES_OUT*DATA_W-1:0] r_data;
  logic [SEL_W-1:0]            r_sel;
  logic                        r_valid;
  genvar j;
  for (j = 0; j < LANES_OUT; j++) begin : g_lane
    assign w_mux[lane_lo(j, DATA_W) +: DATA_W] = i_sel[SEL_IDX] ? i_data[lane_lo(2*j+1, DATA_W) +: DATA_W]
                                                                : i_data[lane_lo(2*j, DATA_W) +: DATA_W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_data  <= w_mux;
      r_sel   <= i_sel;
      r_valid <= i_valid;
    end
  assign o_data  = r_data;
  assign o_sel   = r_sel;
  assign o_valid = r_valid;
endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined NUM_IN:1 mux tree, one register per level, valid/ready with global stall
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_data/in_sel (upstream),
//        out_valid/out_ready/out_data/out_sel (downstream), out_par (only with MUX_TREE_PIPE_PARITY_EN)
// Option: define MUX_TREE_PIPE_PARITY_EN to add the registered even-parity output out_par.
module mux_tree_pipe import mux_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel
`ifdef MUX_TREE_PIPE_PARITY_EN
  ,
  output logic                     out_par
`endif
);
  // all tree levels flattened: level k holds NUM_IN>>k lanes, final level is the single output lane
  localparam int TOT = lvl_off(NUM_IN, SEL_W) + 1;
  logic                     w_adv;
  logic [TOT*DATA_W-1:0]    w_bus;
  logic [SEL_W-1:0]         w_s [SEL_W+1];
  logic [SEL_W:0]           w_v;
  if (NUM_IN < 2 || NUM_IN > MUX_MAX_IN || (NUM_IN & (NUM_IN - 1)) != 0 || SEL_W != clog2(NUM_IN)) begin : g_bad_cfg
    $error("mux_tree_pipe: NUM_IN must be a power of two in [2, MUX_MAX_IN] and SEL_W must stay derived");
  end
  // single global advance: every level shifts or every level holds, no bubble collapsing
  assign w_adv    = !w_v[SEL_W] | out_ready;
  assign in_ready = w_adv;
  assign w_bus[0 +: NUM_IN*DATA_W] = in_data;
  assign w_s[0] = in_sel;
  assign w_v[0] = in_valid;
  genvar k;
  for (k = 0; k < SEL_W; k++) begin : g_st
    mux_tree_stage #(
      .DATA_W  (DATA_W),
      .LANES_IN(NUM_IN >> k),
      .SEL_W   (SEL_W),
      .SEL_IDX (k)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_adv),
      .i_valid(w_v[k]),
      .i_data (w_bus[lvl_off(NUM_IN, k)*DATA_W +: (NUM_IN >> k)*DATA_W]),
      .i_sel  (w_s[k]),
      .o_valid(w_v[k+1]),
      .o_data (w_bus[lvl_off(NUM_IN, k+1)*DATA_W +: (NUM_IN >> (k+1))*DATA_W]),
      .o_sel  (w_s[k+1])
    );
  end
  assign out_valid = w_v[SEL_W];
  assign out_data  = w_bus[(TOT-1)*DATA_W +: DATA_W];
  assign out_sel   = w_s[SEL_W];
`ifdef MUX_TREE_PIPE_PARITY_EN
  localparam int LAST = lvl_off(NUM_IN, SEL_W - 1);
  logic [DATA_W-1:0] w_last;
  logic              r_par;
  // parity of the root mux result, registered alongside the final data register
  assign w_last = w_s[SEL_W-1][SEL_W-1] ? w_bus[(LAST+1)*DATA_W +: DATA_W] : w_bus[LAST*DATA_W +: DATA_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_par <= 1'b0;
    else if (w_adv) r_par <= ^w_last;
  assign out_par = r_par;
`endif
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: randomized + directed scoreboard bench for mux_tree_pipe (16:1 and 2:1 builds)
module tb_mux_tree_pipe;
  localparam int DW = 8, N = 16, LAT = 4;
  typedef struct {logic [DW-1:0] d; logic [3:0] s;} item_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [N*DW-1:0] in_data = '0;
  logic [3:0] in_sel = '0, out_sel;
  logic [DW-1:0] out_data;
  logic v2_in = 1'b0, r2_in, v2_out, o2_rdy = 1'b1, s2 = 1'b0, s2_out;
  logic [2*DW-1:0] d2 = '0;
  logic [DW-1:0] q2;
`ifdef MUX_TREE_PIPE_PARITY_EN
  logic out_par, par2;
`endif
  mux_tree_pipe #(.DATA_W(DW), .NUM_IN(N)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
`ifdef MUX_TREE_PIPE_PARITY_EN
    , .out_par(out_par)
`endif
  );
  mux_tree_pipe #(.DATA_W(DW), .NUM_IN(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2_in), .in_ready(r2_in), .in_data(d2), .in_sel(s2),
    .out_valid(v2_out), .out_ready(o2_rdy), .out_data(q2), .out_sel(s2_out)
`ifdef MUX_TREE_PIPE_PARITY_EN
    , .out_par(par2)
`endif
  );
  int total = 0, bad = 0;
  item_t sb[$];
  logic acc_q[$];
  bit exact = 0, p_stall = 0, accepted = 0, obs_valid = 0, e2_v = 0;
  logic [DW-1:0] p_data, obs_data, e2_d;
  logic [3:0] p_sel;
  logic e2_s;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [N*DW-1:0] pat(input int kind);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*DW +: DW] = kind == 0 ? 8'hA0 + i[7:0] : kind == 1 ? (i[0] ? 8'h00 : 8'hFF)
                    : kind == 2 ? (i[0] ? 8'hFF : 8'h00) : i[7:0];
    return v;
  endfunction
  function automatic logic [N*DW-1:0] rnd();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N*DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic cyc(input logic iv, input logic [N*DW-1:0] din, input logic [3:0] sel, input logic ordy);
    item_t e;
    @(negedge clk);
    in_valid = iv; in_data = din; in_sel = sel; out_ready = ordy;
    v2_in = 1'($urandom_range(0, 1)); d2 = 16'($urandom); s2 = 1'($urandom_range(0, 1));
    #1;
    chk("in_ready", in_ready, !out_valid || ordy);
    if (exact) chk("lat_valid", out_valid, acc_q.pop_front());
    if (p_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, p_data);
      chk("stall_sel", out_sel, p_sel);
    end
`ifdef MUX_TREE_PIPE_PARITY_EN
    if (out_valid) chk("parity", out_par, ^out_data);
    if (v2_out) chk("n2_parity", par2, ^q2);
`endif
    if (out_valid && ordy) begin
      if (sb.size() == 0) chk("sb_underflow", out_valid, 0);
      else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_sel", out_sel, e.s);
      end
    end
    accepted = iv && in_ready;
    if (accepted) sb.push_back('{din[sel*DW +: DW], sel});
    if (exact) acc_q.push_back(accepted);
    p_stall = out_valid && !ordy; p_data = out_data; p_sel = out_sel;
    obs_valid = out_valid; obs_data = out_data;
    chk("n2_ready", r2_in, 1);
    chk("n2_valid", v2_out, e2_v);
    if (e2_v) begin
      chk("n2_data", q2, e2_d);
      chk("n2_sel", s2_out, e2_s);
    end
    e2_v = v2_in; e2_d = d2[s2*DW +: DW]; e2_s = s2;
    @(posedge clk);
  endtask
  task automatic arm_exact();
    acc_q.delete();
    repeat (LAT) acc_q.push_back(1'b0);
    exact = 1;
  endtask
  task automatic drain_exact();
    exact = 0;
    repeat (LAT + 1) cyc(0, '0, 0, 1);
    arm_exact();
  endtask
  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; v2_in = 0;
    rst_n = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_n2_valid", v2_out, 0);
    sb.delete(); p_stall = 0; e2_v = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("rst_rel_in_ready", in_ready, 1);
    arm_exact();
  endtask
  initial begin
    #2;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    arm_exact();
    for (int i = 0; i < N; i++) cyc(1, pat(0), 4'(i), 1);
    repeat (LAT) cyc(0, '0, 0, 1);
    exact = 0;
    begin
      int i = 0, c = 0;
      while (i < N && c < 100) begin
        cyc(1, pat(0), 4'(i), !(c >= 9 && c <= 11));
        if (c >= 9 && c <= 12) chk("stall_hold_a5", obs_data, 8'hA5);
        if (c >= 9 && c <= 11) chk("stall_no_accept", accepted, 0);
        if (c == 13) chk("after_stall_a6", {obs_valid, obs_data}, 9'h1A6);
        if (accepted) i++;
        c++;
      end
      chk("stall_stream_done", i, N);
    end
    drain_exact();
    cyc(1, pat(0), 3, 1);
    cyc(0, pat(0), 7, 1);
    cyc(1, pat(0), 12, 1);
    cyc(1, pat(1), 0, 1);
    cyc(1, pat(1), 15, 1);
    cyc(1, pat(2), 0, 1);
    cyc(1, pat(2), 15, 1);
    cyc(1, pat(3), 7, 1);
    cyc(1, pat(3), 3, 1);
    repeat (LAT) cyc(0, '0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, pat(0), 4'(i), 1);
    chk("pre_rst_valid", obs_valid, 1);
    exact = 0;
    do_reset();
    exact = 0;
    for (int i = 0; i < 500; i++)
      cyc(1'($urandom_range(0, 1)), rnd(), 4'($urandom), $urandom_range(0, 3) != 0);
    drain_exact();
    for (int i = 0; i < 300; i++) cyc(1'($urandom_range(0, 3) != 0), rnd(), 4'($urandom), 1);
    repeat (LAT + 2) cyc(0, '0, 0, 1);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined NUM_IN:1 multiplexer built as a binary tree of 2:1 stages.
- Same select convention as the combinational 4:1 tree: sel[0] resolves the first (leaf) level and the MSB resolves the root.
- One register per tree level, with a valid/ready handshake and a global stall.
- Used wherever wide input selection must close timing at clk; supersedes fixed-size combinational mux trees.

Parameters:
- DATA_W, 8, width of each input lane and of the output.
- NUM_IN, 16, number of input lanes; must be a power of two, >= 2.
- SEL_W, $clog2(NUM_IN), select width; also equals pipeline depth LAT. Derived; do not override.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_sel qualify this cycle.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  NUM_IN*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- in_sel  input  SEL_W  lane index to forward.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts output.
- out_data  output  DATA_W  selected lane, LAT cycles after acceptance.
- out_sel  output  SEL_W  in_sel echoed, aligned with out_data.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, all data/sel registers 0; out_valid=0, out_data=0, out_sel=0. in_ready=1 immediately after reset.
- Handshake: adv = !out_valid | out_ready. in_ready = adv (combinational). All stages shift together when adv=1 and all hold when adv=0.
  - Transfer in: in_valid & in_ready.
  - Transfer out: out_valid & out_ready.
- Stage k (k=0..SEL_W-1):
  - Input: 2^(SEL_W-k) lanes. Output: 2^(SEL_W-k-1) lanes.
  - Output lane j = sel_k[k] ? lane 2j+1 : lane 2j.
  - sel_k and valid_k advance alongside the data.
- Latency: exactly LAT=SEL_W cycles from accept to out_valid with no stall. Throughput: 1 per cycle while out_ready=1.
- Bubbles: when adv=1 and in_valid=0, a valid=0 bubble is inserted. Data registers still load, but their contents are don't-care.
- Stall: when out_valid=1 and out_ready=0, out_data and out_sel are held stable and no stage advances.
  - in_ready=0 even if upstream stages hold bubbles. The global stall is deliberate; there is no bubble collapsing.
- Ordering: outputs leave in acceptance order; nothing is dropped or duplicated.
- Reset mid-operation: all in-flight items are discarded and out_valid drops in the same cycle rst_n falls.
- in_sel is sampled only on acceptance; changing it while not accepted has no effect.
- NUM_IN=2: LAT=1, a single stage.

Optional Feature:
- Macro MUX_TREE_PIPE_PARITY_EN.
- Defined:
  - Extra output port out_par (1 bit) = even parity (XOR reduce) of out_data.
  - Registered in the final stage, so it is aligned with out_data and held during stall.
  - Reset value 0.
- Undefined: port out_par absent; no parity logic.

Decomposition:
- Shared package mux_pkg holds:
  - the clog2 helper function;
  - constant MUX_MAX_IN=256, the upper bound checked by an elaboration assertion;
  - a lane-slicing helper.
- One natural sub-module, mux_tree_stage. Parameters: DATA_W, LANES_IN, SEL_W. It contains:
  - the lane-pair mux using a configured sel bit index;
  - the register with enable;
  - valid/sel pass-through.
- The top generates SEL_W instances and computes adv.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run -> out_valid=0, out_data=0 the same cycle; after release in_ready=1.
- Streaming (NUM_IN=16, DATA_W=8): lane i=8'hA0+i, in_sel 0..15 back-to-back, out_ready=1 -> out_data 8'hA0..8'hAF in order. First out_valid 4 cycles after the first accept; then one output per cycle; out_sel matches.
- Stall: while out_valid=1 with out_data=8'hA5 (sel 5), hold out_ready=0 for 3 cycles -> out_data stays 8'hA5, in_ready=0, and no new accept occurs. After release the next item follows the next cycle.
- Bubbles: in_valid pattern 1,0,1 with sel 3, x, 12 -> out_valid pattern 1,0,1 at cycles LAT..LAT+2 with data 8'hA3, 8'hAC.
- Boundaries: sel=0 and sel=NUM_IN-1 with lanes = all-ones/zeros alternating -> correct extreme lane. Also NUM_IN=2 build: LAT=1, sel=1 -> lane1.
- Parity (MUX_TREE_PIPE_PARITY_EN defined): selected lane 8'h07 -> out_par=1; 8'h03 -> out_par=0; out_par held during stall.
